// File: rtl/uart_tx_pkg.sv
// Shared types and helpers for the word-to-byte UART sender.
package uart_tx_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    BUSY,
    DONE
  } sender_state_t;

  // Limit a requested byte count to what the word can actually hold.
  function automatic int unsigned clamp_bytes(input int unsigned n, input int unsigned max_n);
    return (n > max_n) ? max_n : n;
  endfunction

endpackage

// File: rtl/uart_word_sender.sv
// Serialises a 1..WORD_BYTES-byte word through the byte-wide UART TX core,
// with a start-acknowledge timeout so a dead transmitter cannot stall the
// host-command path.
module uart_word_sender
  import uart_tx_pkg::*;
#(
  parameter int WORD_BYTES  = 4,
  parameter bit MSB_FIRST   = 1'b1,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                               clk_50mhz,
  input  logic                               reset,
  input  logic                               activate,
  input  logic [BYTE_W*WORD_BYTES-1:0]       word,
  input  logic [$clog2(WORD_BYTES+1)-1:0]    nbytes,
  output logic                               done,
  output logic                               error,
  output logic                               busy,
  input  logic                               tx_active,
  output logic [BYTE_W-1:0]                  tx_data,
  output logic                               tx_start
);

  localparam int WORD_W = BYTE_W * WORD_BYTES;
  localparam int CNT_W  = $clog2(WORD_BYTES + 1);
  localparam int TO_W   = $clog2(ACK_TIMEOUT);

  sender_state_t            state_q, state_nxt;
  logic [WORD_W-1:0]        shift_q, shift_nxt;
  logic [CNT_W-1:0]         rem_q, rem_nxt;
  logic [TO_W-1:0]          to_q, to_nxt;
  logic                     done_nxt, error_nxt, busy_nxt, tx_start_nxt;
  logic [BYTE_W-1:0]        tx_data_nxt;

  // Byte at the sending end of the shift register.
  function automatic logic [BYTE_W-1:0] send_byte(input logic [WORD_W-1:0] v);
    if (MSB_FIRST) return v[WORD_W-1 -: BYTE_W];
    else           return v[BYTE_W-1:0];
  endfunction

  // Move the next byte to the sending end.
  function automatic logic [WORD_W-1:0] advance(input logic [WORD_W-1:0] v);
    if (MSB_FIRST) return v << BYTE_W;
    else           return v >> BYTE_W;
  endfunction

  // Next-state and next-output decode; outputs are registered below.
  always_comb begin
    state_nxt    = state_q;
    shift_nxt    = shift_q;
    rem_nxt      = rem_q;
    to_nxt       = to_q;
    done_nxt     = done;
    error_nxt    = error;
    busy_nxt     = busy;
    tx_data_nxt  = tx_data;
    tx_start_nxt = 1'b0;

    case (state_q)
      IDLE: begin
        done_nxt  = 1'b0;
        error_nxt = 1'b0;
        // Another master owning the UART only delays the launch.
        if (activate && !tx_active) begin
          shift_nxt = word;
          rem_nxt   = CNT_W'(clamp_bytes(32'(nbytes), 32'(WORD_BYTES)));
          if (rem_nxt == '0) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
          end else begin
            tx_data_nxt  = send_byte(word);
            tx_start_nxt = 1'b1;
            to_nxt       = '0;
            busy_nxt     = 1'b1;
            state_nxt    = ACK;
          end
        end
      end

      ACK: begin
        if (tx_active) begin
          state_nxt = BUSY;
        end else if (to_q == TO_W'(ACK_TIMEOUT - 1)) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
          error_nxt = 1'b1;
          busy_nxt  = 1'b0;
        end else begin
          to_nxt = to_q + TO_W'(1);
        end
      end

      BUSY: begin
        if (!tx_active) begin
          if (rem_q == CNT_W'(1)) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
            error_nxt = 1'b0;
            busy_nxt  = 1'b0;
          end else begin
            shift_nxt    = advance(shift_q);
            rem_nxt      = rem_q - CNT_W'(1);
            tx_data_nxt  = send_byte(shift_nxt);
            tx_start_nxt = 1'b1;
            to_nxt       = '0;
            state_nxt    = ACK;
          end
        end
      end

      DONE: begin
        done_nxt = 1'b1;
        busy_nxt = 1'b0;
        // Dispatcher acknowledges by dropping activate.
        if (!activate) begin
          state_nxt = IDLE;
          done_nxt  = 1'b0;
          error_nxt = 1'b0;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // State, datapath and output registers; reset aborts any transfer at once.
  always_ff @(posedge clk_50mhz or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      rem_q    <= '0;
      to_q     <= '0;
      done     <= 1'b0;
      error    <= 1'b0;
      busy     <= 1'b0;
      tx_data  <= '0;
      tx_start <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      shift_q  <= shift_nxt;
      rem_q    <= rem_nxt;
      to_q     <= to_nxt;
      done     <= done_nxt;
      error    <= error_nxt;
      busy     <= busy_nxt;
      tx_data  <= tx_data_nxt;
      tx_start <= tx_start_nxt;
    end
  end

endmodule

// File: tb/tb_uart_word_sender.sv
// Bench for uart_word_sender: an MSB-first and an LSB-first instance share
// the command inputs, each with its own UART core model.
module tb_uart_word_sender;

  logic        clk_50mhz = 1'b0;
  logic        reset     = 1'b0;
  logic        activate  = 1'b0;
  logic [31:0] word      = '0;
  logic [2:0]  nbytes    = '0;
  logic        uart_en   = 1'b1;
  logic        ext_busy  = 1'b0;

  logic        done_a, error_a, busy_a, tx_start_a, tx_active_a;
  logic [7:0]  tx_data_a;
  logic        done_b, error_b, busy_b, tx_start_b, tx_active_b;
  logic [7:0]  tx_data_b;

  logic act_a = 1'b0, act_b = 1'b0;
  int   left_a = 0, left_b = 0;
  logic prev_a = 1'b0, prev_b = 1'b0;
  int   wide_a = 0, wide_b = 0;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];

  int n_chk  = 0;
  int n_fail = 0;

  assign tx_active_a = act_a | ext_busy;
  assign tx_active_b = act_b | ext_busy;

  always #10 clk_50mhz = ~clk_50mhz;

  uart_word_sender #(.WORD_BYTES(4), .MSB_FIRST(1'b1), .ACK_TIMEOUT(16)) u_msb (
    .clk_50mhz(clk_50mhz), .reset(reset), .activate(activate), .word(word),
    .nbytes(nbytes), .done(done_a), .error(error_a), .busy(busy_a),
    .tx_active(tx_active_a), .tx_data(tx_data_a), .tx_start(tx_start_a)
  );

  uart_word_sender #(.WORD_BYTES(4), .MSB_FIRST(1'b0), .ACK_TIMEOUT(16)) u_lsb (
    .clk_50mhz(clk_50mhz), .reset(reset), .activate(activate), .word(word),
    .nbytes(nbytes), .done(done_b), .error(error_b), .busy(busy_b),
    .tx_active(tx_active_b), .tx_data(tx_data_b), .tx_start(tx_start_b)
  );

  // UART core models: tx_active rises one cycle after tx_start, lasts 10 cycles.
  always @(posedge clk_50mhz) begin
    if (uart_en && tx_start_a) begin act_a <= 1'b1; left_a <= 9; end
    else if (left_a > 0) left_a <= left_a - 1;
    else act_a <= 1'b0;
    if (uart_en && tx_start_b) begin act_b <= 1'b1; left_b <= 9; end
    else if (left_b > 0) left_b <= left_b - 1;
    else act_b <= 1'b0;
  end

  // Byte monitors; also count tx_start pulses longer than one cycle.
  always @(negedge clk_50mhz) begin
    if (tx_start_a) begin q_a.push_back(tx_data_a); if (prev_a) wide_a <= wide_a + 1; end
    if (tx_start_b) begin q_b.push_back(tx_data_b); if (prev_b) wide_b <= wide_b + 1; end
    prev_a <= tx_start_a;
    prev_b <= tx_start_b;
  end

  typedef struct {
    logic [31:0] word;
    logic [2:0]  nbytes;
    int          n_exp;
    logic [31:0] seq_msb;
    logic [31:0] seq_lsb;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 2000 && !ok; c++) begin
      if (done_a && done_b) ok = 1'b1;
      else @(negedge clk_50mhz);
    end
  endtask

  task automatic chk_bytes(input string nm, input int n_exp,
                           input logic [31:0] sa, input logic [31:0] sb);
    chk({nm, " count msb"}, 32'(q_a.size()), 32'(n_exp));
    chk({nm, " count lsb"}, 32'(q_b.size()), 32'(n_exp));
    for (int k = 0; k < n_exp; k++) begin
      if (k < q_a.size()) chk($sformatf("%s msb byte%0d", nm, k), 32'(q_a[k]), 32'(sa[31-8*k -: 8]));
      if (k < q_b.size()) chk($sformatf("%s lsb byte%0d", nm, k), 32'(q_b[k]), 32'(sb[31-8*k -: 8]));
    end
  endtask

  task automatic run_vec(input int i);
    bit ok;
    string nm;
    vec_t v;
    v  = vecs[i];
    nm = $sformatf("vec%0d", i);
    q_a.delete(); q_b.delete();
    word = v.word; nbytes = v.nbytes; activate = 1'b1;
    @(negedge clk_50mhz);
    chk({nm, " start latency"}, 32'(tx_start_a), 32'(v.n_exp > 0));
    chk({nm, " done at launch"}, 32'(done_a), 32'(v.n_exp == 0));
    word = ~v.word; nbytes = 3'd1;
    wait_done(ok);
    chk({nm, " done seen"}, 32'(ok), 32'd1);
    chk({nm, " error msb"}, 32'(error_a), 32'd0);
    chk({nm, " error lsb"}, 32'(error_b), 32'd0);
    chk({nm, " busy"}, 32'(busy_a), 32'd0);
    chk_bytes(nm, v.n_exp, v.seq_msb, v.seq_lsb);
    if (v.n_exp > 0) begin
      chk({nm, " tx_data hold"}, 32'(tx_data_a), 32'(v.seq_msb[31-8*(v.n_exp-1) -: 8]));
    end
    activate = 1'b0;
    @(negedge clk_50mhz);
    chk({nm, " done cleared"}, 32'(done_a), 32'd0);
    chk({nm, " done cleared lsb"}, 32'(done_b), 32'd0);
  endtask

  initial begin
    bit ok;
    int n;
    bit hit;

    vecs[0] = '{32'h12345678, 3'd4, 4, 32'h12345678, 32'h78563412};
    vecs[1] = '{32'hA1B2C3D4, 3'd2, 2, 32'hA1B20000, 32'hD4C30000};
    vecs[2] = '{32'hDEADBEEF, 3'd7, 4, 32'hDEADBEEF, 32'hEFBEADDE};
    vecs[3] = '{32'h0A0B0C0D, 3'd3, 3, 32'h0A0B0C00, 32'h0D0C0B00};
    vecs[4] = '{32'hCAFEF00D, 3'd0, 0, 32'h00000000, 32'h00000000};
    vecs[5] = '{32'h5566AA99, 3'd1, 1, 32'h55000000, 32'h99000000};

    // Reset state
    repeat (3) @(negedge clk_50mhz);
    chk("reset done",     32'(done_a),     32'd0);
    chk("reset error",    32'(error_a),    32'd0);
    chk("reset busy",     32'(busy_a),     32'd0);
    chk("reset tx_start", 32'(tx_start_a), 32'd0);
    chk("reset tx_data",  32'(tx_data_a),  32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk_50mhz);

    for (int i = 0; i < 6; i++) run_vec(i);

    // Dead transmitter: error after ACK_TIMEOUT cycles
    uart_en = 1'b0;
    q_a.delete(); q_b.delete();
    word = 32'h12345678; nbytes = 3'd4; activate = 1'b1;
    @(negedge clk_50mhz);
    chk("timeout start", 32'(tx_start_a), 32'd1);
    n = 0; hit = 1'b0;
    for (int i = 1; i <= 40 && !hit; i++) begin
      @(negedge clk_50mhz);
      if (done_a) begin hit = 1'b1; n = i; end
    end
    chk("timeout cycles", 32'(n), 32'd16);
    chk("timeout error msb", 32'(error_a), 32'd1);
    chk("timeout error lsb", 32'(error_b), 32'd1);
    chk("timeout busy", 32'(busy_a), 32'd0);
    chk("timeout one start", 32'(q_a.size()), 32'd1);
    repeat (2) @(negedge clk_50mhz);
    chk("timeout done held", 32'(done_a), 32'd1);
    chk("timeout error held", 32'(error_a), 32'd1);
    activate = 1'b0;
    @(negedge clk_50mhz);
    chk("timeout done clr", 32'(done_a), 32'd0);
    chk("timeout error clr", 32'(error_a), 32'd0);
    uart_en = 1'b1;
    @(negedge clk_50mhz);
    run_vec(0);

    // Asynchronous reset while in BUSY after byte 2
    q_a.delete(); q_b.delete();
    word = 32'h12345678; nbytes = 3'd4; activate = 1'b1;
    n = 0;
    while (q_a.size() < 2 && n < 500) begin @(negedge clk_50mhz); n++; end
    chk("rst reached byte2", 32'(q_a.size()), 32'd2);
    repeat (3) @(negedge clk_50mhz);
    #3 reset = 1'b0;
    #1;
    chk("rst tx_start", 32'(tx_start_a), 32'd0);
    chk("rst tx_data",  32'(tx_data_a),  32'd0);
    chk("rst done",     32'(done_a),     32'd0);
    chk("rst error",    32'(error_a),    32'd0);
    chk("rst busy",     32'(busy_a),     32'd0);
    chk("rst tx_data lsb", 32'(tx_data_b), 32'd0);
    @(negedge clk_50mhz);
    reset = 1'b1;
    q_a.delete(); q_b.delete();
    wait_done(ok);
    chk("rst restart done", 32'(ok), 32'd1);
    chk_bytes("rst restart", 4, 32'h12345678, 32'h78563412);
    activate = 1'b0;
    @(negedge clk_50mhz);

    // Other master holds tx_active; activate dropped right after launch
    ext_busy = 1'b1;
    q_a.delete(); q_b.delete();
    word = 32'h12345678; nbytes = 3'd4; activate = 1'b1;
    repeat (5) @(negedge clk_50mhz);
    chk("held no start", 32'(q_a.size()), 32'd0);
    chk("held not busy", 32'(busy_a), 32'd0);
    ext_busy = 1'b0;
    @(negedge clk_50mhz);
    chk("start after release", 32'(tx_start_a), 32'd1);
    activate = 1'b0;
    wait_done(ok);
    chk("pulse done seen", 32'(ok), 32'd1);
    chk("pulse error", 32'(error_a), 32'd0);
    @(negedge clk_50mhz);
    chk("done single cycle", 32'(done_a), 32'd0);
    chk_bytes("pulse", 4, 32'h12345678, 32'h78563412);

    chk("start width msb", 32'(wide_a), 32'd0);
    chk("start width lsb", 32'(wide_b), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
